phase_shift_ctrl: RTL and testbench

- Sequencer/arbiter for the MMCM dynamic phase-shift port (ps_en/ps_inc/ps_done).
- Tracks the absolute phase of the shifted clock and accepts absolute target-phase requests from two requesters: req0 = CPU/register path, req1 = trigger-delay logic.
- For each request it computes the shortest signed path, modulo one clock period, and issues single steps with the ps_done handshake.
- Includes a ps_done watchdog and lock-loss error handling.

---
 rtl/phase_ctrl_pkg.sv | 21 ++
 rtl/ps_req_arbiter.sv | 46 ++++
 rtl/phase_shift_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_phase_shift_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_ctrl_pkg.sv
// Shared definitions for the MMCM dynamic phase-shift sequencer.
package phase_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_STEP,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned PHASE_STEPS_DEF = 560;

  function automatic int unsigned half_of(input int unsigned n);
    return n / 2;
  endfunction

  localparam int unsigned HALF_STEPS = half_of(PHASE_STEPS_DEF);

endpackage

// File: rtl/ps_req_arbiter.sv
// Two-way round-robin arbiter; latches the winner index and its target at grant.
module ps_req_arbiter #(
  parameter int unsigned PHASE_BITS = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_take,
  input  logic                  i_commit,
  input  logic                  i_req0_valid,
  input  logic [PHASE_BITS-1:0] i_req0_target,
  input  logic                  i_req1_valid,
  input  logic [PHASE_BITS-1:0] i_req1_target,
  output logic                  o_idx,
  output logic [PHASE_BITS-1:0] o_target
);

  logic                  r_last;
  logic                  r_idx;
  logic [PHASE_BITS-1:0] r_target;
  logic                  w_pick1;

  // On contention the requester not served last wins; r_last resets to 1 so req0 goes first.
  always_comb begin
    w_pick1 = i_req1_valid && (!i_req0_valid || !r_last);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last   <= 1'b1;
      r_idx    <= 1'b0;
      r_target <= '0;
    end else begin
      if (i_take) begin
        r_idx    <= w_pick1;
        r_target <= w_pick1 ? i_req1_target : i_req0_target;
      end
      if (i_commit) begin
        r_last <= r_idx;
      end
    end
  end

  assign o_idx    = r_idx;
  assign o_target = r_target;

endmodule

// File: rtl/phase_shift_ctrl.sv
// MMCM phase-shift sequencer: arbitrates absolute-phase requests and steps the
// shortest way round the period with the PSEN/PSDONE handshake.
module phase_shift_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_BITS   = 12,
  parameter int unsigned PHASE_STEPS  = PHASE_STEPS_DEF,
  parameter int unsigned TIMEOUT_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clock_locked,
  input  logic                  req0_valid,
  input  logic [PHASE_BITS-1:0] req0_target,
  output logic                  req0_ack,
  input  logic                  req1_valid,
  input  logic [PHASE_BITS-1:0] req1_target,
  output logic                  req1_ack,
  input  logic                  err_clear,
  output logic                  ps_en,
  output logic                  ps_inc,
  input  logic                  ps_done,
  output logic                  busy,
  output logic                  error,
  output logic                  range_err,
  output logic [PHASE_BITS-1:0] cur_phase
);

  localparam int unsigned DW = PHASE_BITS + 1;
  localparam logic [DW-1:0]         L_STEPS = DW'(PHASE_STEPS);
  localparam logic [DW-1:0]         L_HALF  = DW'(half_of(PHASE_STEPS));
  localparam logic [PHASE_BITS-1:0] L_LAST  = PHASE_BITS'(PHASE_STEPS - 1);

  state_t                  r_state;
  logic [PHASE_BITS-1:0]   r_cur;
  logic [PHASE_BITS-1:0]   r_count;
  logic [TIMEOUT_BITS-1:0] r_wd;
  logic                    r_en;
  logic                    r_inc;
  logic                    r_range_err;

  logic                    w_take;
  logic                    w_commit;
  logic                    w_idx;
  logic [PHASE_BITS-1:0]   w_target;
  logic [DW-1:0]           w_tgt_ext;
  logic [DW-1:0]           w_cur_ext;
  logic [DW-1:0]           w_delta;
  logic [PHASE_BITS-1:0]   w_up_cnt;
  logic [PHASE_BITS-1:0]   w_dn_cnt;
  logic                    w_out_of_range;

  assign w_take   = (r_state == S_IDLE) && clock_locked && (req0_valid || req1_valid);
  assign w_commit = (r_state == S_DONE) && clock_locked;

  ps_req_arbiter #(
    .PHASE_BITS (PHASE_BITS)
  ) u_arb (
    .i_clk         (clock),
    .i_rst_n       (reset_n),
    .i_take        (w_take),
    .i_commit      (w_commit),
    .i_req0_valid  (req0_valid),
    .i_req0_target (req0_target),
    .i_req1_valid  (req1_valid),
    .i_req1_target (req1_target),
    .o_idx         (w_idx),
    .o_target      (w_target)
  );

  // Forward distance modulo the period; the target is known < PHASE_STEPS whenever it is used.
  always_comb begin
    w_tgt_ext      = {1'b0, w_target};
    w_cur_ext      = {1'b0, r_cur};
    w_out_of_range = (w_tgt_ext >= L_STEPS);
    if (w_tgt_ext >= w_cur_ext) begin
      w_delta = w_tgt_ext - w_cur_ext;
    end else begin
      w_delta = w_tgt_ext + L_STEPS - w_cur_ext;
    end
    w_up_cnt = PHASE_BITS'(w_delta);
    w_dn_cnt = PHASE_BITS'(L_STEPS - w_delta);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_count     <= '0;
      r_wd        <= '0;
      r_en        <= 1'b0;
      r_inc       <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!clock_locked) begin
            r_state <= S_ERROR;
            r_inc   <= 1'b0;
          end else if (w_out_of_range) begin
            r_range_err <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_delta == '0) begin
            r_state <= S_DONE;
          end else begin
            r_inc   <= (w_delta <= L_HALF);
            r_count <= (w_delta <= L_HALF) ? w_up_cnt : w_dn_cnt;
            r_en    <= 1'b1;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_wd <= '0;
          if (!clock_locked) begin
            r_state <= S_ERROR;
            r_inc   <= 1'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Lock loss beats ps_done, which beats a watchdog expiring in the same cycle.
          if (!clock_locked) begin
            r_state <= S_ERROR;
            r_inc   <= 1'b0;
          end else if (ps_done) begin
            if (r_inc) begin
              r_cur <= (r_cur == L_LAST) ? '0 : r_cur + 1'b1;
            end else begin
              r_cur <= (r_cur == '0) ? L_LAST : r_cur - 1'b1;
            end
            r_count <= r_count - 1'b1;
            if (r_count == PHASE_BITS'(1)) begin
              r_state <= S_DONE;
            end else begin
              r_en    <= 1'b1;
              r_state <= S_STEP;
            end
          end else if (&r_wd) begin
            r_state <= S_ERROR;
            r_inc   <= 1'b0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE: begin
          if (!clock_locked) begin
            r_state <= S_ERROR;
            r_inc   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (err_clear && clock_locked) begin
            r_cur       <= '0;
            r_range_err <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_ERROR;
          r_inc   <= 1'b0;
        end
      endcase
    end
  end

  // Ack is qualified by lock so a lock loss in DONE leaves the request un-acked.
  assign req0_ack  = w_commit && !w_idx;
  assign req1_ack  = w_commit &&  w_idx;
  assign ps_en     = r_en;
  assign ps_inc    = r_inc;
  assign busy      = (r_state != S_IDLE);
  assign error     = (r_state == S_ERROR);
  assign range_err = r_range_err;
  assign cur_phase = r_cur;

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// Self-checking bench for phase_shift_ctrl: MMCM responder plus a shortest-path phase model.
module tb_phase_shift_ctrl;

  localparam int N  = 560;
  localparam int PB = 12;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clock_locked = 1'b1;
  logic          req0_valid = 1'b0;
  logic [PB-1:0] req0_target = '0;
  logic          req0_ack;
  logic          req1_valid = 1'b0;
  logic [PB-1:0] req1_target = '0;
  logic          req1_ack;
  logic          err_clear = 1'b0;
  logic          ps_en;
  logic          ps_inc;
  logic          ps_done = 1'b0;
  logic          busy;
  logic          error;
  logic          range_err;
  logic [PB-1:0] cur_phase;

  int tests = 0;
  int fails = 0;

  // Reference state
  int m_phase = 0;
  int m_last  = 1;
  int m_rng   = 0;

  // MMCM responder
  int pulses   = 0;
  int incs     = 0;
  int done_cnt = -1;
  bit mmcm_on  = 1'b1;

  phase_shift_ctrl #(
    .PHASE_BITS   (PB),
    .PHASE_STEPS  (N),
    .TIMEOUT_BITS (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clock_locked (clock_locked),
    .req0_valid   (req0_valid),
    .req0_target  (req0_target),
    .req0_ack     (req0_ack),
    .req1_valid   (req1_valid),
    .req1_target  (req1_target),
    .req1_ack     (req1_ack),
    .err_clear    (err_clear),
    .ps_en        (ps_en),
    .ps_inc       (ps_inc),
    .ps_done      (ps_done),
    .busy         (busy),
    .error        (error),
    .range_err    (range_err),
    .cur_phase    (cur_phase)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    ps_done = 1'b0;
    if (done_cnt == 0) begin
      ps_done  = 1'b1;
      done_cnt = -1;
    end else if (done_cnt > 0) begin
      done_cnt = done_cnt - 1;
    end
    if (ps_en === 1'b1) begin
      pulses = pulses + 1;
      if (ps_inc === 1'b1) incs = incs + 1;
      if (mmcm_on) done_cnt = int'($urandom_range(0, 3));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_phase = 0;
    m_last  = 1;
    m_rng   = 0;
  endtask

  task automatic serve(input int who, input int tgt, input int unlocked_hold);
    int rng, d, up, steps, cyc, ack_at, first_en, other;
    rng   = (tgt >= N) ? 1 : 0;
    d     = rng ? 0 : (tgt - m_phase + N) % N;
    up    = (d <= N / 2) ? 1 : 0;
    steps = up ? d : N - d;
    pulses = 0;
    incs   = 0;
    if (who == 0) begin req0_target = PB'(tgt); req0_valid = 1'b1; end
    else          begin req1_target = PB'(tgt); req1_valid = 1'b1; end
    if (unlocked_hold > 0) begin
      clock_locked = 1'b0;
      repeat (unlocked_hold) @(negedge clock);
      chk("pending_unlocked_busy", 32'(busy), 0);
      chk("pending_unlocked_error", 32'(error), 0);
      clock_locked = 1'b1;
    end
    ack_at = -1; first_en = -1; other = 0; cyc = 0;
    while (ack_at < 0 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (ps_en === 1'b1 && first_en < 0) first_en = cyc;
      if ((who == 0 ? req1_ack : req0_ack) === 1'b1) other++;
      if ((who == 0 ? req0_ack : req1_ack) === 1'b1) begin
        ack_at = cyc;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("ack_seen", 32'(ack_at >= 0), 1);
    if (steps == 0) chk("ack_latency_nostep", 32'(ack_at), 2);
    else            chk("first_psen_latency", 32'(first_en), 2);
    @(negedge clock);
    chk("step_count", 32'(pulses), 32'(steps));
    chk("inc_count", 32'(incs), up ? 32'(steps) : 0);
    chk("wrong_ack", 32'(other), 0);
    if (!rng) m_phase = tgt;
    m_rng  = m_rng | rng;
    m_last = who;
    chk("cur_phase", 32'(cur_phase), 32'(m_phase));
    chk("busy_after", 32'(busy), 0);
    chk("range_err", 32'(range_err), 32'(m_rng));
  endtask

  task automatic both(input int t0, input int t1);
    int first_id, second_id, n_ack, cyc, exp_first;
    exp_first = (m_last == 1) ? 0 : 1;
    req0_target = PB'(t0); req1_target = PB'(t1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    first_id = -1; second_id = -1; n_ack = 0; cyc = 0;
    while (n_ack < 2 && cyc < 6000) begin
      @(negedge clock);
      cyc++;
      if (req0_ack === 1'b1) begin
        if (n_ack == 0) first_id = 0; else second_id = 0;
        n_ack++; req0_valid = 1'b0;
      end
      if (req1_ack === 1'b1) begin
        if (n_ack == 0) first_id = 1; else second_id = 1;
        n_ack++; req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    chk("rr_first", 32'(first_id), 32'(exp_first));
    chk("rr_second", 32'(second_id), 32'(1 - exp_first));
    m_phase = (exp_first == 0) ? t1 : t0;
    m_last  = 1 - exp_first;
    chk("rr_cur_phase", 32'(cur_phase), 32'(m_phase));
  endtask

  task automatic recover();
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    m_phase = 0;
    m_rng   = 0;
    chk("recover_error", 32'(error), 0);
    chk("recover_phase", 32'(cur_phase), 0);
    chk("recover_range_err", 32'(range_err), 0);
    chk("recover_busy", 32'(busy), 0);
  endtask

  initial begin
    int acks, cyc, seen, tgt, who;
    do_reset();
    @(negedge clock);
    chk("rst_phase", 32'(cur_phase), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_range_err", 32'(range_err), 0);
    chk("rst_ps_en", 32'(ps_en), 0);
    chk("rst_acks", 32'({req0_ack, req1_ack}), 0);

    // Directed paths: short inc, wrap-around dec, exact-half ties.
    serve(0, 10, 0);
    serve(1, 550, 0);
    serve(0, 0, 0);
    serve(1, 280, 0);
    serve(0, 0, 0);

    // Round-robin from reset.
    do_reset();
    both(10, 300);
    both(50, 500);

    // Out of range, zero distance, pending while unlocked.
    serve(0, 600, 0);
    serve(1, m_phase, 0);
    serve(0, (m_phase + 3) % N, 4);

    // Reset mid-operation abandons the request.
    req1_target = PB'((m_phase + 200) % N);
    req1_valid  = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clock);
      if (req1_ack === 1'b1) acks++;
    end
    do_reset();
    chk("midreset_ack", 32'(acks), 0);
    chk("midreset_phase", 32'(cur_phase), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_range_err", 32'(range_err), 0);
    repeat (6) @(negedge clock);
    chk("done_in_idle_ignored", 32'(cur_phase), 0);
    serve(0, 5, 0);

    // Watchdog: withhold ps_done.
    mmcm_on = 1'b0;
    req0_target = PB'(m_phase + 5);
    req0_valid  = 1'b1;
    seen = 0; acks = 0; cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (req0_ack === 1'b1) acks++;
      if (error === 1'b1) seen = 1;
    end
    req0_valid = 1'b0;
    chk("wd_error", 32'(seen), 1);
    chk("wd_latency_min", 32'(cyc >= 250), 1);
    chk("wd_ps_en", 32'(ps_en), 0);
    chk("wd_ps_inc", 32'(ps_inc), 0);
    chk("wd_busy", 32'(busy), 1);
    chk("wd_ack", 32'(acks), 0);
    chk("wd_phase", 32'(cur_phase), 32'(m_phase));
    recover();

    // Lock loss in WAIT, then err_clear while unlocked is ignored.
    req0_target = PB'(m_phase + 7);
    req0_valid  = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (req0_ack === 1'b1) acks++;
    end
    clock_locked = 1'b0;
    @(negedge clock);
    req0_valid = 1'b0;
    chk("lock_error", 32'(error), 1);
    chk("lock_ps_inc", 32'(ps_inc), 0);
    chk("lock_ack", 32'(acks + int'(req0_ack)), 0);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    @(negedge clock);
    chk("clear_unlocked_ignored", 32'(error), 1);
    clock_locked = 1'b1;
    recover();
    mmcm_on = 1'b1;
    repeat (6) @(negedge clock);

    // Random requests against the model.
    for (int i = 0; i < 25; i++) begin
      who = int'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N, N + 60))
                                        : int'($urandom_range(0, N - 1));
      serve(who, tgt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
